mmio_gpio: RTL and testbench
============================

// Module: mmio_gpio
// PURPOSE
//  Memory-mapped GPIO peripheral; next generation of the single-register IO block on the data bus.
//  Replaces one write-only output with N_OUT readable/writable output registers.
//  Adds N_IN synchronised input channels with sticky rising-edge flags (write-1-to-clear) and an irq line.
//  Sits beside data_mem. Selected by the top-level address decode (data_addr >= 256). Drives seven_segment/LEDs.
// PARAMETERS
//  WIDTH    32  register/data width; must be 32 (four byte lanes)
//  N_OUT    4   number of output registers, 1..16
//  N_IN     2   number of input channels, 1..8
//  ADDR_W   8   byte-offset width of addr
//  OUT_RST  0   reset value of every output register
// PORTS
//  clk       in   1             system clock, rising edge
//  rst_n     in   1             synchronous reset, active low
//  cs        in   1             chip select from top-level decode
//  addr      in   ADDR_W        byte offset; idx = addr[ADDR_W-1:2], lane = addr[1:0]
//  wr_en     in   1             write strobe (MemWrite), qualified by cs
//  rd_en     in   1             read strobe (MemRead), qualified by cs
//  mem_len   in   3             access size: 0 = byte, 1 = half, 2 = word (MemLen encoding)
//  wr_data   in   WIDTH         write data, right-aligned
//  rd_data   out  WIDTH         read data, registered
//  rd_valid  out  1             rd_data valid this cycle
//  gpio_in   in   N_IN*WIDTH    asynchronous external inputs; channel j = [j*WIDTH +: WIDTH]
//  gpio_out  out  N_OUT*WIDTH   output registers, concatenated as for gpio_in
//  irq       out  1             OR of all edge-flag bits
// BEHAVIOUR
//  Register map (idx):
//   0..N_OUT-1                  OUT[i], RW
//   N_OUT..N_OUT+N_IN-1         IN[j], RO, synchronised value
//   N_OUT+N_IN..N_OUT+2*N_IN-1  EDGE[j], RO, W1C
//   All other idx: unmapped. Reads return 0. Writes are ignored.
//  Reset (rst_n == 0 at clk edge):
//   OUT = OUT_RST; EDGE = 0; sync flops = 0; rd_data = 0; rd_valid = 0; irq = 0.
//   Reset overrides any access in the same cycle.
//  Writes apply when cs & wr_en, at the clk edge:
//   byte: lane = addr[1:0]; writes wr_data[7:0] into bits [8*lane +: 8].
//   half: lane = {addr[1],0}; writes wr_data[15:0]. addr[0] is ignored.
//   word: writes all 32 bits. addr[1:0] is ignored.
//   mem_len 3..7: no write.
//   IN writes are ignored. EDGE writes clear every flag bit whose data bit is 1, within the enabled lanes.
//   gpio_out reflects the new value in the cycle after the write edge.
//  Reads: cs & rd_en at edge N -> rd_data = full 32-bit register and rd_valid = 1 during cycle N+1.
//   Lane extraction and sign-extension are done by the core.
//   With no read, rd_valid = 0 and rd_data holds its last value.
//   Read and write to the same idx in one cycle: the read returns the old value.
//   cs & wr_en & rd_en: both are performed.
//  Input path, per bit: two-flop synchroniser s1 -> s2, then a previous-value flop p.
//   IN[j] = s2. A change on gpio_in is visible in IN two edges later.
//   Rising edge = s2 & ~p. It sets the corresponding EDGE bit.
//   Set and W1C clear in the same cycle: set wins and the flag stays 1.
//  irq = |EDGE, registered. It asserts the cycle after a flag sets and drops the cycle after the last flag clears.
//  All arithmetic is unsigned. idx comparisons use full ADDR_W-2 bits, with no aliasing.
// STRUCTURE
//  Shared package mmio_pkg:
//   MemLen encodings LEN_B = 3'd0, LEN_H = 3'd1, LEN_W = 3'd2.
//   Function byte_mask(len, lane) -> 4-bit lane enable.
//   IO_BASE = 256.
//  Sub-module io_sync #(WIDTH): one per input channel (clk, rst_n, async_in, sync_out, rise).
//   Generate loop over N_IN.
//  Top level holds the OUT/EDGE registers, the decode and the read mux.
// TESTING
//  T1 reset: gpio_out = 0, irq = 0, rd_valid = 0.
//   Read idx 0 -> rd_data 0x00000000 with rd_valid one cycle later.
//  T2 byte/half/word writes:
//   word write 0x11223344 to idx 1.
//   Then byte 0xAA to addr 0x06 -> OUT[1] = 0x11AA3344.
//   Then half 0xBEEF to addr 0x04 -> 0x11AABEEF.
//   gpio_out[63:32] matches.
//  T3 sync latency: gpio_in ch0 bit3 goes 0->1 between edges.
//   IN[0] bit3 = 1 after exactly two edges. EDGE[0] = 0x8 one edge later. irq = 1 the following cycle.
//  T4 W1C with collision: EDGE[0] = 0x9. Write 0x1 -> EDGE[0] = 0x8.
//   Write 0x8 in the same cycle that a new rise on bit3 is detected -> bit3 stays 1.
//  T5 unmapped and illegal: write to idx N_OUT+2*N_IN -> no state change; read -> 0.
//   mem_len = 3 write to idx 0 -> OUT[0] unchanged. Write with cs = 0 -> ignored.
//  T6 reset mid-operation: assert rst_n = 0 in the same cycle as a word write and a pending edge.
//   Next cycle: OUT = OUT_RST, EDGE = 0, irq = 0, rd_valid = 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: definitions shared by the memory-mapped IO blocks on the data bus.
//   LEN_B/LEN_H/LEN_W : MemLen access-size encodings driven by the core
//   IO_BASE           : first data address decoded to the IO region
//   byte_mask()       : 4-bit lane enable for an access size and lane
//   lane_bits()       : expands a 4-bit lane enable to a 32-bit bit mask
package mmio_pkg;

  localparam logic [2:0] LEN_B = 3'd0;
  localparam logic [2:0] LEN_H = 3'd1;
  localparam logic [2:0] LEN_W = 3'd2;

  localparam int unsigned IO_BASE = 32'd256;

  // Half-word accesses ignore addr[0]; word accesses ignore the whole lane.
  // Unsupported sizes enable no lanes, which turns the access into a no-op.
  function automatic logic [3:0] byte_mask(input logic [2:0] len, input logic [1:0] lane);
    logic [3:0] m;
    case (len)
      LEN_B:   m = 4'b0001 << lane;
      LEN_H:   m = lane[1] ? 4'b1100 : 4'b0011;
      LEN_W:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/mmio_gpio_if.sv
// mmio_gpio_if: data-bus slave port of the IO region.
//   cs, addr, wr_en, rd_en, mem_len, wr_data : driven by the core / address decode
//   rd_data, rd_valid                        : driven by the peripheral, registered
interface mmio_gpio_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
);
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;
  logic [2:0]        mem_len;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;

  modport master (
    output cs, addr, wr_en, rd_en, mem_len, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  cs, addr, wr_en, rd_en, mem_len, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/mmio_gpio_io_sync.sv
// io_sync: per-bit two-flop synchroniser plus previous-value flop for one input channel.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_async_in     : asynchronous external input
//   o_sync_out     : synchronised value (second stage)
//   o_rise         : one-cycle pulse per bit on a synchronised 0->1 transition
module io_sync #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async_in,
  output logic [WIDTH-1:0] o_sync_out,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_p;

  // Synchroniser chain and previous-value history.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_p  <= '0;
    end else begin
      r_s1 <= i_async_in;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end

  assign o_sync_out = r_s2;
  assign o_rise     = r_s2 & ~r_p;

endmodule

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO peripheral on the data bus.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : slave bus port (select, byte offset, strobes, size, data, read return)
//   i_gpio_in      : N_IN asynchronous input channels, channel j at [j*WIDTH +: WIDTH]
//   o_gpio_out     : N_OUT output registers, concatenated the same way
//   o_irq          : registered OR of every edge-flag bit
// Register map by word index: OUT[0..N_OUT-1] RW, then IN[0..N_IN-1] RO,
// then EDGE[0..N_IN-1] RO/W1C; every other index reads 0 and ignores writes.
module mmio_gpio
  import mmio_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          N_OUT   = 4,
  parameter int          N_IN    = 2,
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] OUT_RST = 32'h0000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  mmio_gpio_if.slave             bus,
  input  logic [N_IN*WIDTH-1:0]  i_gpio_in,
  output logic [N_OUT*WIDTH-1:0] o_gpio_out,
  output logic                   o_irq
);

  localparam int IDX_W = ADDR_W - 2;

  logic [N_OUT-1:0][WIDTH-1:0] r_out;
  logic [N_IN-1:0][WIDTH-1:0]  r_edge;
  logic [WIDTH-1:0]            r_rd_data;
  logic                        r_rd_valid;
  logic                        r_irq;

  logic [IDX_W-1:0]            w_idx;
  logic [3:0]                  w_bytes;
  logic [WIDTH-1:0]            w_bmask;
  logic [WIDTH-1:0]            w_wdata;
  logic                        w_wr;
  logic                        w_rd;
  logic [N_OUT-1:0]            w_out_hit;
  logic [N_IN-1:0]             w_in_hit;
  logic [N_IN-1:0]             w_edge_hit;
  logic [N_IN-1:0][WIDTH-1:0]  w_sync;
  logic [N_IN-1:0][WIDTH-1:0]  w_rise;
  logic [N_IN-1:0][WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]            w_rd_mux;

  assign w_idx   = bus.addr[ADDR_W-1:2];
  assign w_bytes = byte_mask(bus.mem_len, bus.addr[1:0]);
  assign w_bmask = lane_bits(w_bytes);
  assign w_wr    = bus.cs & bus.wr_en;
  assign w_rd    = bus.cs & bus.rd_en;

  // Replicate right-aligned write data onto every lane; the lane mask picks the target.
  always_comb begin
    w_wdata = bus.wr_data;
    case (bus.mem_len)
      LEN_B:   w_wdata = {4{bus.wr_data[7:0]}};
      LEN_H:   w_wdata = {2{bus.wr_data[15:0]}};
      default: w_wdata = bus.wr_data;
    endcase
  end

  // Full-width index compare, so no register aliases at a higher index.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out_dec
      assign w_out_hit[gi] = (w_idx == IDX_W'(gi));
    end
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      assign w_in_hit[gi]   = (w_idx == IDX_W'(N_OUT + gi));
      assign w_edge_hit[gi] = (w_idx == IDX_W'(N_OUT + N_IN + gi));
      assign w_clr[gi]      = (w_wr && w_edge_hit[gi]) ? (w_wdata & w_bmask) : '0;

      io_sync #(.WIDTH(WIDTH)) u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_async_in (i_gpio_in[gi*WIDTH +: WIDTH]),
        .o_sync_out (w_sync[gi]),
        .o_rise     (w_rise[gi])
      );
    end
  endgenerate

  // Read mux over pre-edge register values; unmapped indices select nothing.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_rd_mux = w_rd_mux | (w_out_hit[i] ? r_out[i] : '0);
    end
    for (int j = 0; j < N_IN; j++) begin
      w_rd_mux = w_rd_mux | (w_in_hit[j] ? w_sync[j] : '0)
                          | (w_edge_hit[j] ? r_edge[j] : '0);
    end
  end

  // Register file, edge flags, read return and interrupt.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out      <= {N_OUT{OUT_RST}};
      r_edge     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_wr && w_out_hit[i]) begin
          r_out[i] <= (r_out[i] & ~w_bmask) | (w_wdata & w_bmask);
        end
      end
      // A rise detected in the same cycle as its W1C clear keeps the flag set.
      for (int j = 0; j < N_IN; j++) begin
        r_edge[j] <= (r_edge[j] & ~w_clr[j]) | w_rise[j];
      end
      r_irq      <= |r_edge;
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign o_gpio_out   = r_out;
  assign o_irq        = r_irq;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed, self-checking bench for mmio_gpio (N_OUT=4, N_IN=2).
// Map: OUT 0x00..0x0C, IN 0x10/0x14, EDGE 0x18/0x1C, first unmapped 0x20.
module tb_mmio_gpio;
  import mmio_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  gpio_in;
  logic [127:0] gpio_out;
  logic         irq;
  int           n_checks = 0;
  int           n_errors = 0;

  mmio_gpio_if #(.WIDTH(32), .ADDR_W(8)) bus ();

  mmio_gpio #(
    .WIDTH(32), .N_OUT(4), .N_IN(2), .ADDR_W(8), .OUT_RST(32'h0000_0000)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .i_gpio_in  (gpio_in),
    .o_gpio_out (gpio_out),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cs    = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [2:0] len, input logic [31:0] d);
    bus.cs = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 1'b0;
    bus.addr = a; bus.mem_len = len; bus.wr_data = d;
    tick();
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.cs = 1'b1; bus.rd_en = 1'b1; bus.wr_en = 1'b0;
    bus.addr = a; bus.mem_len = LEN_W;
    tick();
    idle();
    chk({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
    chk(tag, bus.rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    gpio_in = 64'd0;
    bus.addr = 8'd0; bus.mem_len = LEN_W; bus.wr_data = 32'd0;
    idle();

    // T1 reset
    tick(); tick();
    chk("rst_out0", gpio_out[31:0], 32'd0);
    chk("rst_out3", gpio_out[127:96], 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    rst_n = 1'b1;
    rd_chk("rst_rd0", 8'h00, 32'h0000_0000);
    tick();
    chk("valid_drop", {31'd0, bus.rd_valid}, 32'd0);

    // T2 byte/half/word writes
    wr(8'h04, LEN_W, 32'h1122_3344);
    rd_chk("w_word", 8'h04, 32'h1122_3344);
    wr(8'h06, LEN_B, 32'h0000_00AA);
    rd_chk("w_byte", 8'h04, 32'h11AA_3344);
    wr(8'h04, LEN_H, 32'h0000_BEEF);
    rd_chk("w_half", 8'h04, 32'h11AA_BEEF);
    chk("gpio_out1", gpio_out[63:32], 32'h11AA_BEEF);
    wr(8'h07, LEN_H, 32'h0000_1234);
    rd_chk("w_half_hi", 8'h04, 32'h1234_BEEF);
    // simultaneous read and write: read returns the old value
    bus.cs = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    bus.addr = 8'h04; bus.mem_len = LEN_W; bus.wr_data = 32'h0BAD_F00D;
    tick();
    idle();
    chk("rw_old_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("rw_old", bus.rd_data, 32'h1234_BEEF);
    rd_chk("rw_new", 8'h04, 32'h0BAD_F00D);
    chk("gpio_out1b", gpio_out[63:32], 32'h0BAD_F00D);

    // T3 sync latency: ch0 bit3 rises between edges
    gpio_in[3] = 1'b1;
    bus.cs = 1'b1; bus.rd_en = 1'b1; bus.addr = 8'h10;
    tick();
    chk("in_e1", bus.rd_data, 32'h0000_0000);
    tick();
    chk("in_e2", bus.rd_data, 32'h0000_0000);
    tick();
    chk("in_e3", bus.rd_data, 32'h0000_0008);
    chk("irq_e3", {31'd0, irq}, 32'd0);
    bus.addr = 8'h18;
    tick();
    idle();
    chk("edge_e4", bus.rd_data, 32'h0000_0008);
    chk("irq_e4", {31'd0, irq}, 32'd1);

    // T4 W1C, then a set/clear collision
    gpio_in[0] = 1'b1;
    tick(); tick(); tick();
    rd_chk("edge_9", 8'h18, 32'h0000_0009);
    wr(8'h18, LEN_W, 32'h0000_0001);
    rd_chk("w1c_b0", 8'h18, 32'h0000_0008);
    wr(8'h18, LEN_B, 32'h0000_0008);
    rd_chk("w1c_all", 8'h18, 32'h0000_0000);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    gpio_in[3] = 1'b0;
    tick(); tick(); tick();
    gpio_in[3] = 1'b1;
    tick(); tick();
    wr(8'h18, LEN_W, 32'h0000_0008);
    rd_chk("collide", 8'h18, 32'h0000_0008);
    chk("irq_coll", {31'd0, irq}, 32'd1);

    // T5 unmapped, illegal size, cs low, IN write
    wr(8'h00, LEN_W, 32'hCAFE_F00D);
    wr(8'h20, LEN_W, 32'hDEAD_BEEF);
    rd_chk("unmap_rd", 8'h20, 32'h0000_0000);
    rd_chk("unmap_hi", 8'hFC, 32'h0000_0000);
    chk("um_out0", gpio_out[31:0], 32'hCAFE_F00D);
    chk("um_out1", gpio_out[63:32], 32'h0BAD_F00D);
    chk("um_out2", gpio_out[95:64], 32'h0000_0000);
    chk("um_out3", gpio_out[127:96], 32'h0000_0000);
    wr(8'h00, 3'd3, 32'h0000_5555);
    rd_chk("len3", 8'h00, 32'hCAFE_F00D);
    bus.cs = 1'b0; bus.wr_en = 1'b1; bus.addr = 8'h00;
    bus.mem_len = LEN_W; bus.wr_data = 32'h0000_0077;
    tick();
    idle();
    rd_chk("cs_low", 8'h00, 32'hCAFE_F00D);
    wr(8'h10, LEN_W, 32'hFFFF_FFFF);
    rd_chk("in_ro", 8'h10, 32'h0000_0009);

    // T6 reset in the same cycle as a write, a read and a pending edge
    gpio_in[32] = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    bus.cs = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    bus.addr = 8'h00; bus.mem_len = LEN_W; bus.wr_data = 32'h1234_5678;
    tick();
    idle();
    chk("mr_out0", gpio_out[31:0], 32'd0);
    chk("mr_out1", gpio_out[63:32], 32'd0);
    chk("mr_irq", {31'd0, irq}, 32'd0);
    chk("mr_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("mr_rdata", bus.rd_data, 32'd0);
    rst_n = 1'b1;
    rd_chk("mr_edge0", 8'h18, 32'h0000_0000);
    rd_chk("mr_edge1", 8'h1C, 32'h0000_0000);
    rd_chk("mr_rd0", 8'h00, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
